lock_sequencer: RTL and testbench



---
 rtl/lock_sequencer.sv | 120 ++++++++++++
 tb/tb_lock_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/lock_sequencer.sv
// lock_sequencer: unlock-attempt controller with stored password, retry counter and timed lockout.
// Latency: enter sampled at E0 -> CHECK after E0 -> OPEN or IDLE/LOCKOUT after E1; out/buzzer decode state.
// No backpressure: enter is only accepted in IDLE; pulses arriving in other states are dropped.
// Optional feature macro LOCK_AUTORELOCK_EN: OPEN relocks by itself after OPEN_CYCLES idle cycles.
module lock_sequencer #(
  parameter int              PW           = 4,
  parameter logic [PW-1:0]   DEFAULT_PASS = 4'b1010,
  parameter int              MAX_TRIES    = 4,
  parameter int              LOCK_CYCLES  = 1024,
  parameter int              OPEN_CYCLES  = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [PW-1:0] code_in,
  input  logic          enter,
  input  logic          close,
  input  logic          change,
  output logic          out,
  output logic          buzzer,
  output logic [2:0]    count,
  output logic [1:0]    state
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CHECK   = 2'd1;
  localparam logic [1:0] OPEN    = 2'd2;
  localparam logic [1:0] LOCKOUT = 2'd3;

  // One shared down-counter serves both LOCKOUT and (optionally) OPEN, so size it for the larger load.
  localparam int MAX_CYC = (LOCK_CYCLES > OPEN_CYCLES) ? LOCK_CYCLES : OPEN_CYCLES;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);
`ifdef LOCK_AUTORELOCK_EN
  localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
`endif
  localparam logic [2:0]    MAX_T     = 3'(MAX_TRIES);

  logic [PW-1:0] pass_q;
  logic [PW-1:0] code_q;
  logic [TW-1:0] timer;
  logic [2:0]    count_inc;

  assign count_inc = count + 3'd1;

  // Outputs are pure decodes of the state register, so they never glitch on inputs.
  assign out    = (state == OPEN);
  assign buzzer = (state == LOCKOUT);

  // Main sequencer: every register is updated here; reset overrides all inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      pass_q <= DEFAULT_PASS;
      code_q <= '0;
      count  <= '0;
      timer  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // close/change have no meaning while locked and are ignored here.
          if (enter) begin
            code_q <= code_in;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (code_q == pass_q) begin
            state <= OPEN;
            count <= '0;
`ifdef LOCK_AUTORELOCK_EN
            timer <= OPEN_LOAD;
`endif
          end else begin
            // count can reach MAX_TRIES only on the transition into LOCKOUT, which clears it on exit,
            // so it never wraps.
            count <= count_inc;
            if (count_inc == MAX_T) begin
              state <= LOCKOUT;
              timer <= LOCK_LOAD;
            end else begin
              state <= IDLE;
            end
          end
        end
        OPEN: begin
          // A change coinciding with close still stores the new password before relocking.
          if (change) begin
            pass_q <= code_in;
          end
`ifdef LOCK_AUTORELOCK_EN
          if (close) begin
            state <= IDLE;
          end else if (change) begin
            timer <= OPEN_LOAD;
          end else if (timer == '0) begin
            state <= IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
`else
          if (close) begin
            state <= IDLE;
          end
`endif
        end
        LOCKOUT: begin
          if (timer == '0) begin
            state <= IDLE;
            count <= '0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lock_sequencer.sv
// Scoreboard bench for lock_sequencer: expectations are queued with an absolute cycle stamp when
// stimulus is driven, and a negedge monitor pops and compares them when that cycle is reached.
// Builds with or without LOCK_AUTORELOCK_EN; the OPEN-timeout section adapts to the macro.
module tb_lock_sequencer;

  localparam int MAXT = 4;
  localparam int LCY  = 16;
  localparam int OCY  = 8;

  localparam int S_IDLE = 0, S_CHECK = 1, S_OPEN = 2, S_LOCK = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] code_in = 4'd0;
  logic       enter = 1'b0, close = 1'b0, change = 1'b0;
  logic       out, buzzer;
  logic [2:0] count;
  logic [1:0] state;

  lock_sequencer #(
    .PW(4), .DEFAULT_PASS(4'b1010), .MAX_TRIES(MAXT), .LOCK_CYCLES(LCY), .OPEN_CYCLES(OCY)
  ) dut (
    .clk(clk), .reset(reset), .code_in(code_in), .enter(enter), .close(close), .change(change),
    .out(out), .buzzer(buzzer), .count(count), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    cyc;
    string tag;
    int    st;
    int    o;
    int    b;
    int    cnt;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor: compare every expectation due this cycle, away from the rising edge.
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        chk({q[i].tag, ".state"},  int'(state),  q[i].st);
        chk({q[i].tag, ".out"},    int'(out),    q[i].o);
        chk({q[i].tag, ".buzzer"}, int'(buzzer), q[i].b);
        chk({q[i].tag, ".count"},  int'(count),  q[i].cnt);
        q.delete(i);
      end
    end
  end

  // Queue an expectation dc edges from now.
  task automatic push(input int dc, input string tag, input int st, input int o, input int b, input int cnt);
    exp_t e;
    e.cyc = cyc + dc; e.tag = tag; e.st = st; e.o = o; e.b = b; e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic drive(input logic [3:0] c, input logic en, input logic cl, input logic ch);
    code_in = c; enter = en; close = cl; change = ch;
    @(posedge clk); #1;
    enter = 1'b0; close = 1'b0; change = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(code_in, 1'b0, 1'b0, 1'b0);
  endtask

  // One submitted code: CHECK on the next cycle, then the outcome the lock rules dictate.
  task automatic try_code(input logic [3:0] c, input int cnt_before, input bit ok, input string tag);
    push(1, {tag, "_chk"}, S_CHECK, 0, 0, cnt_before);
    if (ok)                         push(2, tag, S_OPEN, 1, 0, 0);
    else if (cnt_before + 1 == MAXT) push(2, tag, S_LOCK, 0, 1, cnt_before + 1);
    else                            push(2, tag, S_IDLE, 0, 0, cnt_before + 1);
    drive(c, 1'b1, 1'b0, 1'b0);
    idle(1);
  endtask

  initial begin
    @(posedge clk); #1;
    push(1, "reset", S_IDLE, 0, 0, 0);
    drive(4'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // Correct code opens two cycles after enter; enter in OPEN is dropped; close relocks.
    try_code(4'b1010, 0, 1, "t1_open");
    push(1, "t1_enter_ign", S_OPEN, 1, 0, 0);
    drive(4'b0001, 1'b1, 1'b0, 1'b0);
    push(1, "t1_close", S_IDLE, 0, 0, 0);
    drive(4'b0000, 1'b0, 1'b1, 1'b0);

    // Three wrong codes; the third is followed by an enter during CHECK that must be dropped.
    try_code(4'b0001, 0, 0, "t2_w1");
    try_code(4'b0001, 1, 0, "t2_w2");
    push(1, "t2_w3_chk", S_CHECK, 0, 0, 2);
    push(2, "t2_w3", S_IDLE, 0, 0, 3);
    push(3, "t2_drop", S_IDLE, 0, 0, 3);
    drive(4'b0001, 1'b1, 1'b0, 1'b0);
    drive(4'b0001, 1'b1, 1'b0, 1'b0);
    idle(1);
    try_code(4'b1010, 3, 1, "t2_open");
    drive(4'b0000, 1'b0, 1'b1, 1'b0);

    // Four wrong codes -> lockout for exactly LCY cycles; a correct enter inside is ignored.
    for (int i = 0; i < MAXT; i++) try_code(4'b0111, i, 0, $sformatf("t3_w%0d", i + 1));
    push(LCY - 1, "t3_lock_last", S_LOCK, 0, 1, MAXT);
    push(LCY, "t3_lock_end", S_IDLE, 0, 0, 0);
    idle(2);
    push(1, "t3_lock_ign", S_LOCK, 0, 1, MAXT);
    drive(4'b1010, 1'b1, 1'b0, 1'b0);
    idle(LCY);

    // Password change, relock, old code fails, new code opens; change+close together.
    try_code(4'b1010, 0, 1, "t4_open");
    push(1, "t4_change", S_OPEN, 1, 0, 0);
    drive(4'b0110, 1'b0, 1'b0, 1'b1);
    push(1, "t4_close", S_IDLE, 0, 0, 0);
    drive(4'b0000, 1'b0, 1'b1, 1'b0);
    try_code(4'b1010, 0, 0, "t4_old");
    try_code(4'b0110, 1, 1, "t4_new");
    push(1, "t4_chg_close", S_IDLE, 0, 0, 0);
    drive(4'b0011, 1'b0, 1'b1, 1'b1);
    try_code(4'b0011, 0, 1, "t4_new2");
    drive(4'b0000, 1'b0, 1'b1, 1'b0);

    // Reset during lockout restores everything, including the default password.
    for (int i = 0; i < MAXT; i++) try_code(4'b0001, i, 0, $sformatf("t5_w%0d", i + 1));
    idle(3);
    reset = 1'b1;
    push(1, "t5_reset", S_IDLE, 0, 0, 0);
    drive(4'b0000, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    push(1, "t5_idle_ign", S_IDLE, 0, 0, 0);
    drive(4'b1111, 1'b0, 1'b1, 1'b1);
    try_code(4'b1010, 0, 1, "t5_default_pw");

`ifdef LOCK_AUTORELOCK_EN
    // Already OPEN from the previous step (first OPEN cycle is now): relock after OCY cycles.
    push(OCY - 1, "t6_open_last", S_OPEN, 1, 0, 0);
    push(OCY, "t6_relock", S_IDLE, 0, 0, 0);
    idle(OCY + 1);
    try_code(4'b1010, 0, 1, "t6_open2");
    idle(3);
    push(1, "t6_change", S_OPEN, 1, 0, 0);
    push(5, "t6_extended", S_OPEN, 1, 0, 0);
    push(OCY, "t6_ext_last", S_OPEN, 1, 0, 0);
    push(OCY + 1, "t6_ext_relock", S_IDLE, 0, 0, 0);
    drive(4'b1010, 1'b0, 1'b0, 1'b1);
    idle(OCY + 1);
`else
    // Without auto-relock OPEN holds indefinitely until close.
    push(OCY + 4, "t6_hold", S_OPEN, 1, 0, 0);
    idle(OCY + 5);
    push(1, "t6_close", S_IDLE, 0, 0, 0);
    drive(4'b0000, 1'b0, 1'b1, 1'b0);
`endif

    idle(2);
    chk("leftover_expectations", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
